// File: rtl/dcache_nway_array.sv
// N-way set-associative tag/data store with true-LRU ages, valid/dirty state and victim reporting.
// Lookup is combinational in the accept cycle; array updates and the response register on the same edge.
`timescale 1ns/1ps
module dcache_nway_array #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 4,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256,
  localparam int AGE_W   = $clog2(WAYS),
  localparam int NSETS   = 2 ** SET_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_op_i,
  input  logic [SET_BITS-1:0] req_set_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  input  logic [LINE_W-1:0]   req_data_i,
  input  logic                req_dirty_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic [AGE_W-1:0]    resp_way_o,
  output logic [LINE_W-1:0]   resp_data_o,
  output logic                victim_valid_o,
  output logic                victim_dirty_o,
  output logic [TAG_W-1:0]    victim_tag_o,
  output logic [LINE_W-1:0]   victim_data_o
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  typedef enum logic {INIT, READY} state_t;
  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

  state_t              state, state_nxt;
  logic [SET_BITS-1:0] cnt;

  logic [WAYS-1:0]   valid_mem [NSETS];
  logic [WAYS-1:0]   dirty_mem [NSETS];
  ages_t             age_mem   [NSETS];
  logic [TAG_W-1:0]  tag_mem   [NSETS][WAYS];
  logic [LINE_W-1:0] data_mem  [NSETS][WAYS];

  logic              accept;
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [AGE_W-1:0]  hit_way, fill_way;
  logic              inv_found;
  ages_t             cur_ages;

  logic              vic_vld, vic_dirty;
  logic [TAG_W-1:0]  vic_tag;
  logic [LINE_W-1:0] vic_data;

  logic              vld_p1, hit_p1, vic_vld_p1, vic_dirty_p1;
  logic [AGE_W-1:0]  way_p1;
  logic [LINE_W-1:0] data_p1, vic_data_p1;
  logic [TAG_W-1:0]  vic_tag_p1;

  // Hit way h becomes MRU; every younger way ages by one, so ages stay a permutation.
  function automatic ages_t touch(input ages_t a, input logic [AGE_W-1:0] h);
    ages_t r;
    for (int w = 0; w < WAYS; w++)
      r[w] = (a[w] < a[h]) ? a[w] + 1'b1 : a[w];
    r[h] = '0;
    return r;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == SET_BITS'(NSETS - 1)) state_nxt = READY;
  end

  always_comb begin
    req_ready_o = (state == READY);
  end

  assign accept   = req_valid_i && req_ready_o;
  assign cur_ages = age_mem[req_set_i];

  always_comb begin
    hit_vec   = '0;
    hit_way   = '0;
    fill_way  = '0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_mem[req_set_i][w] && (tag_mem[req_set_i][w] == req_tag_i);
      if (hit_vec[w]) hit_way = AGE_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[req_set_i][w]) begin
        fill_way  = AGE_W'(w);
        inv_found = 1'b1;
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++)
        if (cur_ages[w] == AGE_W'(WAYS - 1)) fill_way = AGE_W'(w);
    end
  end

  assign hit = |hit_vec;

  always_comb begin
    vic_vld   = 1'b0;
    vic_dirty = 1'b0;
    vic_tag   = '0;
    vic_data  = '0;
    if (req_op_i == OP_FILL && valid_mem[req_set_i][fill_way]) begin
      vic_vld   = 1'b1;
      vic_dirty = dirty_mem[req_set_i][fill_way];
      vic_tag   = tag_mem[req_set_i][fill_way];
      vic_data  = data_mem[req_set_i][fill_way];
    end else if (req_op_i == OP_INVAL && hit && dirty_mem[req_set_i][hit_way]) begin
      vic_vld   = 1'b1;
      vic_dirty = 1'b1;
      vic_tag   = tag_mem[req_set_i][hit_way];
      vic_data  = data_mem[req_set_i][hit_way];
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      valid_mem[cnt] <= '0;
      dirty_mem[cnt] <= '0;
      for (int w = 0; w < WAYS; w++) age_mem[cnt][w] <= AGE_W'(w);
    end else if (accept) begin
      case (req_op_i)
        OP_READ: if (hit) age_mem[req_set_i] <= touch(cur_ages, hit_way);
        OP_WRITE: if (hit) begin
          data_mem[req_set_i][hit_way]  <= req_data_i;
          dirty_mem[req_set_i][hit_way] <= 1'b1;
          age_mem[req_set_i]            <= touch(cur_ages, hit_way);
        end
        OP_FILL: begin
          tag_mem[req_set_i][fill_way]   <= req_tag_i;
          data_mem[req_set_i][fill_way]  <= req_data_i;
          valid_mem[req_set_i][fill_way] <= 1'b1;
          dirty_mem[req_set_i][fill_way] <= req_dirty_i;
          age_mem[req_set_i]             <= touch(cur_ages, fill_way);
        end
        default: if (hit) begin
          valid_mem[req_set_i][hit_way] <= 1'b0;
          dirty_mem[req_set_i][hit_way] <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && req_op_i != OP_FILL) assert ($onehot0(hit_vec));
  end

  // Response stage: registered on the accept edge, held until the next accepted op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1       <= 1'b0;
      hit_p1       <= 1'b0;
      way_p1       <= '0;
      data_p1      <= '0;
      vic_vld_p1   <= 1'b0;
      vic_dirty_p1 <= 1'b0;
      vic_tag_p1   <= '0;
      vic_data_p1  <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        hit_p1       <= hit && (req_op_i != OP_FILL);
        way_p1       <= (req_op_i == OP_FILL) ? fill_way : (hit ? hit_way : '0);
        data_p1      <= (req_op_i == OP_FILL || !hit) ? '0 :
                        (req_op_i == OP_WRITE) ? req_data_i : data_mem[req_set_i][hit_way];
        vic_vld_p1   <= vic_vld;
        vic_dirty_p1 <= vic_dirty;
        vic_tag_p1   <= vic_tag;
        vic_data_p1  <= vic_data;
      end
    end
  end

  assign resp_valid_o   = vld_p1;
  assign resp_hit_o     = hit_p1;
  assign resp_way_o     = way_p1;
  assign resp_data_o    = data_p1;
  assign victim_valid_o = vic_vld_p1;
  assign victim_dirty_o = vic_dirty_p1;
  assign victim_tag_o   = vic_tag_p1;
  assign victim_data_o  = vic_data_p1;

endmodule

// File: tb/tb_dcache_nway_array.sv
// Directed bench for dcache_nway_array: a 2-way instance (a_*) and a 4-way instance (b_*).
`timescale 1ns/1ps
module tb_dcache_nway_array;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, FL = 2'b10, IV = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_valid, a_ready, a_dirty_in, a_rvalid, a_hit, a_way, a_vvalid, a_vdirty;
  logic [1:0]   a_op;
  logic [3:0]   a_set;
  logic [22:0]  a_tag, a_vtag;
  logic [255:0] a_data, a_rdata, a_vdata;

  logic         b_valid, b_ready, b_dirty_in, b_rvalid, b_hit, b_vvalid, b_vdirty;
  logic [1:0]   b_op, b_way;
  logic [3:0]   b_set;
  logic [22:0]  b_tag, b_vtag;
  logic [255:0] b_data, b_rdata, b_vdata;

  dcache_nway_array #(.WAYS(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_op_i(a_op), .req_set_i(a_set), .req_tag_i(a_tag), .req_data_i(a_data),
    .req_dirty_i(a_dirty_in), .resp_valid_o(a_rvalid), .resp_hit_o(a_hit),
    .resp_way_o(a_way), .resp_data_o(a_rdata), .victim_valid_o(a_vvalid),
    .victim_dirty_o(a_vdirty), .victim_tag_o(a_vtag), .victim_data_o(a_vdata));

  dcache_nway_array #(.WAYS(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_op_i(b_op), .req_set_i(b_set), .req_tag_i(b_tag), .req_data_i(b_data),
    .req_dirty_i(b_dirty_in), .resp_valid_o(b_rvalid), .resp_hit_o(b_hit),
    .resp_way_o(b_way), .resp_data_o(b_rdata), .victim_valid_o(b_vvalid),
    .victim_dirty_o(b_vdirty), .victim_tag_o(b_vtag), .victim_data_o(b_vdata));

  int total = 0;
  int fails = 0;
  int n;

  logic [255:0] da, db, dc, dd, d55, d11, zero;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, let it be accepted on the next edge, sample #1 later.
  task automatic op(input bit b, input logic [1:0] o, input logic [3:0] s,
                    input logic [22:0] t, input logic [255:0] d, input logic dty);
    if (!b) begin
      a_valid = 1'b1; a_op = o; a_set = s; a_tag = t; a_data = d; a_dirty_in = dty;
    end else begin
      b_valid = 1'b1; b_op = o; b_set = s; b_tag = t; b_data = d; b_dirty_in = dty;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!(a_ready && b_ready) && cycles < 100) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    da = {8{32'hA0A0_000A}}; db = {8{32'hB0B0_000B}}; dc = {8{32'hC0C0_000C}};
    dd = {8{32'hD0D0_000D}}; d55 = {32{8'h55}}; d11 = {8{32'h1111_2222}}; zero = '0;
    b_valid = 1'b0; b_op = RD; b_set = '0; b_tag = '0; b_data = '0; b_dirty_in = 1'b0;
    // Test 1: request held across reset and INIT
    a_valid = 1'b1; a_op = RD; a_set = 4'd3; a_tag = 23'h1; a_data = '0; a_dirty_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_vvalid", a_vvalid, 0);
    chk("rst_rdata", a_rdata, zero);
    rst = 1'b0;
    wait_ready(n);
    chk("init_cycles", n, 16);
    chk("init_no_resp", a_rvalid, 0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("t1_rvalid", a_rvalid, 1);
    chk("t1_hit", a_hit, 0);
    chk("t1_data", a_rdata, zero);
    @(posedge clk); #1;
    chk("t1_pulse", a_rvalid, 0);

    // Test 2: fills into set 5
    op(0, FL, 4'd5, 23'hA, da, 1'b0);
    chk("t2_fa_way", a_way, 0);
    chk("t2_fa_vvalid", a_vvalid, 0);
    chk("t2_fa_hit", a_hit, 0);
    op(0, FL, 4'd5, 23'hB, db, 1'b0);
    chk("t2_fb_way", a_way, 1);
    chk("t2_fb_vvalid", a_vvalid, 0);
    op(0, RD, 4'd5, 23'hA, zero, 1'b0);
    chk("t2_rd_hit", a_hit, 1);
    chk("t2_rd_way", a_way, 0);
    chk("t2_rd_data", a_rdata, da);

    // Test 3: LRU replacement
    op(0, FL, 4'd5, 23'hC, dc, 1'b1);
    chk("t3_fc_way", a_way, 1);
    chk("t3_fc_vvalid", a_vvalid, 1);
    chk("t3_fc_vdirty", a_vdirty, 0);
    chk("t3_fc_vtag", a_vtag, 23'hB);
    chk("t3_fc_vdata", a_vdata, db);
    op(0, FL, 4'd5, 23'hD, dd, 1'b0);
    chk("t3_fd_way", a_way, 0);
    chk("t3_fd_vtag", a_vtag, 23'hA);
    chk("t3_fd_vdata", a_vdata, da);

    // Test 4: write hit, dirty invalidate, then miss
    op(0, WR, 4'd5, 23'hC, d55, 1'b0);
    chk("t4_wr_hit", a_hit, 1);
    chk("t4_wr_data", a_rdata, d55);
    chk("t4_wr_vvalid", a_vvalid, 0);
    op(0, IV, 4'd5, 23'hC, zero, 1'b0);
    chk("t4_iv_hit", a_hit, 1);
    chk("t4_iv_vvalid", a_vvalid, 1);
    chk("t4_iv_vdirty", a_vdirty, 1);
    chk("t4_iv_vtag", a_vtag, 23'hC);
    chk("t4_iv_vdata", a_vdata, d55);
    op(0, RD, 4'd5, 23'hC, zero, 1'b0);
    chk("t4_rd_hit", a_hit, 0);
    chk("t4_rd_data", a_rdata, zero);
    chk("t4_rd_vvalid", a_vvalid, 0);
    chk("t4_rd_vtag", a_vtag, 0);

    // Test 5: back-to-back fill/read, write miss
    op(0, FL, 4'd7, 23'h11, d11, 1'b0);
    op(0, RD, 4'd7, 23'h11, zero, 1'b0);
    chk("t5_b2b_hit", a_hit, 1);
    chk("t5_b2b_data", a_rdata, d11);
    op(0, WR, 4'd7, 23'h22, d55, 1'b0);
    chk("t5_wm_hit", a_hit, 0);
    chk("t5_wm_data", a_rdata, zero);
    op(0, RD, 4'd7, 23'h22, zero, 1'b0);
    chk("t5_wm_rd22", a_hit, 0);
    op(0, RD, 4'd7, 23'h11, zero, 1'b0);
    chk("t5_wm_rd11", a_rdata, d11);

    // Test 6b: 4-way LRU
    op(1, FL, 4'd2, 23'h101, da, 1'b0);
    op(1, FL, 4'd2, 23'h102, db, 1'b0);
    op(1, FL, 4'd2, 23'h103, dc, 1'b0);
    op(1, FL, 4'd2, 23'h104, dd, 1'b0);
    chk("w4_f4_way", b_way, 3);
    chk("w4_f4_vvalid", b_vvalid, 0);
    op(1, RD, 4'd2, 23'h101, zero, 1'b0);
    chk("w4_rd1_way", b_way, 0);
    op(1, FL, 4'd2, 23'h105, d11, 1'b1);
    chk("w4_f5_way", b_way, 1);
    chk("w4_f5_vtag", b_vtag, 23'h102);
    chk("w4_f5_vdata", b_vdata, db);
    op(1, RD, 4'd2, 23'h102, zero, 1'b0);
    chk("w4_rd2_hit", b_hit, 0);
    op(1, RD, 4'd2, 23'h104, zero, 1'b0);
    chk("w4_rd4_way", b_way, 3);

    // Test 6: reset coinciding with a response edge
    a_valid = 1'b1; a_op = FL; a_set = 4'd5; a_tag = 23'h77; a_data = d55; a_dirty_in = 1'b1;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rvalid", a_rvalid, 0);
    chk("mid_ready", a_ready, 0);
    a_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(n);
    chk("mid_init_cycles", n, 16);
    op(0, RD, 4'd5, 23'hD, zero, 1'b0);
    chk("mid_rd_d", a_hit, 0);
    op(0, RD, 4'd5, 23'h77, zero, 1'b0);
    chk("mid_rd_77", a_hit, 0);
    op(0, RD, 4'd7, 23'h11, zero, 1'b0);
    chk("mid_rd_11", a_hit, 0);
    chk("mid_rd_11_data", a_rdata, zero);
    op(1, RD, 4'd2, 23'h101, zero, 1'b0);
    chk("mid_rd_b101", b_hit, 0);
    chk("mid_rd_b_rvalid", b_rvalid, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
